pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the load enables and bubble-insert controls of the PC and all four pipeline registers.
- Inputs are instruction/data memory handshake status, ID/EX load-use information, and branch resolution in MEM.
- Complements the operand-forwarding logic by handling the hazards forwarding cannot cover: load-use, memory wait, and control redirect. Also keeps saturating stall/flush performance counters.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous active-low reset
- src1_ifid  input  3 (lc3b_reg)  SR1 of the instruction in ID
- src2_ifid  input  3 (lc3b_reg)  SR2/store-source of the instruction in ID
- src1_used, src2_used  input  1 each  the instruction in ID reads that source
- dest_idex  input  3 (lc3b_reg)  destination of the instruction in EX
- idex_memread  input  1  the instruction in EX is a load (LDR/LDB/LDI)
- imem_req, imem_resp  input  1 each  fetch request outstanding / fetch data valid this cycle
- dmem_req, dmem_resp  input  1 each  MEM-stage access active / access complete this cycle
- br_taken_mem  input  1  taken branch/jump resolved in MEM this cycle
- load_pc, load_ifid, load_idex, load_exmem, load_memwb  output  1 each  register advance enables
- bubble_ifid, bubble_idex, bubble_exmem  output  1 each  load a NOP into that register on this edge
- pc_redirect  output  1  select the branch target into the PC
- stall_cnt, flush_cnt  output  CNT_WIDTH each  saturating counters

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=RUN, redirect_pending=0, counters=0.
  - All load_* and bubble_* outputs =0; pc_redirect=0.
- Combinational hazard terms:
  - lu = idex_memread && ((src1_used && dest_idex==src1_ifid) || (src2_used && dest_idex==src2_ifid)). All eight registers are compared; R0 is not excluded.
  - dwait = dmem_req && !dmem_resp.
  - iwait = imem_req && !imem_resp.
- FSM states: RUN, DSTALL, REDIRECT.
- RUN, rules in priority order:
  - dwait: all load_*=0, no bubbles. Next state DSTALL.
  - br_taken_mem && !iwait:
    - load_pc=1, pc_redirect=1.
    - All load_*=1; bubble_ifid, bubble_idex and bubble_exmem=1.
    - flush_cnt+1. Stay in RUN.
  - br_taken_mem && iwait:
    - load_pc=0, load_ifid=0. Downstream advances with load_idex, load_exmem, load_memwb=1.
    - bubble_idex and bubble_exmem=1 (squash younger instructions).
    - Latch redirect_pending=1 and the target-select request. Next state REDIRECT.
  - lu:
    - load_pc=0, load_ifid=0; load_idex=1 with bubble_idex=1; load_exmem, load_memwb=1.
    - stall_cnt+1. Exactly one bubble, since the next cycle the load has reached MEM.
  - iwait:
    - load_pc=0; load_ifid=1 with bubble_ifid=1; rest advance.
    - stall_cnt+1.
  - Otherwise: all load_*=1, no bubbles.
- DSTALL:
  - All load_*=0 and stall_cnt+1 each cycle while dwait.
  - On dmem_resp: same cycle acts as RUN with dwait=0 (normal advance, other hazards evaluated). Next state RUN.
- REDIRECT:
  - Hold load_pc=0; bubble_ifid=1 with load_ifid=1 every cycle. The downstream pipe drains.
  - On imem_resp: the fetched instruction is discarded (bubble_ifid=1); load_pc=1, pc_redirect=1; flush_cnt+1; clear redirect_pending; next state RUN.
  - dwait in REDIRECT: freeze all loads; stay in REDIRECT.
- Counters saturate at all-ones; no wrap.
- Simultaneous events:
  - br_taken_mem and dmem_req cannot both be active (same stage). Flag with an assertion; dwait wins.
  - br_taken_mem with lu in the same cycle: the branch wins and the load-use is discarded, because the ID instruction is flushed.
- reset_n asserted mid-DSTALL or mid-REDIRECT: immediate return to RUN; pending redirect dropped.
- Outputs are combinational from state and inputs; no registered latency beyond the FSM.

Decomposition:
- Shared package lc3b_types: add lc3b_hazard_state_t enum (RUN, DSTALL, REDIRECT); reuse lc3b_reg.
- One sub-module: sat_counter (parameterized width, inc, clear) instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: idex_memread=1, dest_idex=3, src1_ifid=3, src1_used=1 -> for one cycle load_pc=0, load_ifid=0, bubble_idex=1; stall_cnt 0->1; next cycle full advance.
- Data-memory stall: dmem_req=1, dmem_resp=0 for 4 cycles, then resp=1 -> all load_*=0 for 4 cycles; on resp cycle all load_*=1; stall_cnt=4; state returns to RUN.
- Branch, fetch idle: br_taken_mem=1, imem_resp=1 -> pc_redirect=1, bubble_ifid, bubble_idex and bubble_exmem=1 in the same cycle; flush_cnt=1.
- Branch during fetch wait: br_taken_mem=1, imem_req=1, imem_resp=0, then resp after 3 cycles -> REDIRECT for 3 cycles with load_pc=0; the resp cycle gives pc_redirect=1 and bubble_ifid=1; flush_cnt=1.
- Saturation: CNT_WIDTH=4, hold dwait 20 cycles -> stall_cnt sticks at 15.
- Async reset: drop reset_n mid-DSTALL between clock edges -> outputs and counters go to 0 immediately; after release, first cycle is RUN.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register specifiers and hazard-sequencer states.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DSTALL   = 2'd1,
    REDIRECT = 2'd2
  } lc3b_hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear has priority, increment only below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline. Covers the hazards that
// forwarding cannot: load-use, data-memory wait and branch redirect (including a
// redirect that has to wait for an in-flight fetch). Also counts stall/flush cycles.
module pipeline_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  lc3b_reg              src1_ifid,
  input  lc3b_reg              src2_ifid,
  input  logic                 src1_used,
  input  logic                 src2_used,
  input  lc3b_reg              dest_idex,
  input  logic                 idex_memread,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 br_taken_mem,
  output logic                 load_pc,
  output logic                 load_ifid,
  output logic                 load_idex,
  output logic                 load_exmem,
  output logic                 load_memwb,
  output logic                 bubble_ifid,
  output logic                 bubble_idex,
  output logic                 bubble_exmem,
  output logic                 pc_redirect,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  lc3b_hazard_state_t state_q, state_d;
  logic               pend_q, pend_d;

  logic lu, dwait, iwait, eval_run;
  logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
  logic bub_ifid, bub_idex, bub_exmem, redir;
  logic stall_inc, flush_inc;

  // R0 is compared like any other register: a load into R0 still stalls a reader.
  assign lu    = idex_memread && ((src1_used && (dest_idex == src1_ifid)) ||
                                  (src2_used && (dest_idex == src2_ifid)));
  assign dwait = dmem_req && !dmem_resp;
  assign iwait = imem_req && !imem_resp;

  // Next-state and control decode; DSTALL's completion cycle reuses the RUN rules.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ld_pc     = 1'b0;
    ld_ifid   = 1'b0;
    ld_idex   = 1'b0;
    ld_exmem  = 1'b0;
    ld_memwb  = 1'b0;
    bub_ifid  = 1'b0;
    bub_idex  = 1'b0;
    bub_exmem = 1'b0;
    redir     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    eval_run  = 1'b0;

    case (state_q)
      RUN: eval_run = 1'b1;
      DSTALL: begin
        if (dwait) begin
          stall_inc = 1'b1;
        end else begin
          eval_run = 1'b1;
          state_d  = RUN;
        end
      end
      REDIRECT: begin
        if (dwait) begin
          // Whole pipe frozen behind the data access; keep waiting for the fetch.
        end else if (imem_resp) begin
          // Stale fetch is squashed while the branch target enters the PC.
          ld_pc     = 1'b1;
          redir     = pend_q;
          ld_ifid   = 1'b1;
          bub_ifid  = 1'b1;
          ld_idex   = 1'b1;
          ld_exmem  = 1'b1;
          ld_memwb  = 1'b1;
          flush_inc = 1'b1;
          pend_d    = 1'b0;
          state_d   = RUN;
        end else begin
          ld_ifid  = 1'b1;
          bub_ifid = 1'b1;
          ld_idex  = 1'b1;
          ld_exmem = 1'b1;
          ld_memwb = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (eval_run) begin
      if (dwait) begin
        stall_inc = 1'b1;
        state_d   = DSTALL;
      end else if (br_taken_mem && !iwait) begin
        ld_pc     = 1'b1;
        redir     = 1'b1;
        ld_ifid   = 1'b1;
        ld_idex   = 1'b1;
        ld_exmem  = 1'b1;
        ld_memwb  = 1'b1;
        bub_ifid  = 1'b1;
        bub_idex  = 1'b1;
        bub_exmem = 1'b1;
        flush_inc = 1'b1;
      end else if (br_taken_mem) begin
        // Fetch still in flight: squash younger work now, redirect when it returns.
        ld_idex   = 1'b1;
        ld_exmem  = 1'b1;
        ld_memwb  = 1'b1;
        bub_idex  = 1'b1;
        bub_exmem = 1'b1;
        pend_d    = 1'b1;
        state_d   = REDIRECT;
      end else if (lu) begin
        // One bubble suffices: next cycle the load is in MEM and forwarding covers it.
        ld_idex   = 1'b1;
        bub_idex  = 1'b1;
        ld_exmem  = 1'b1;
        ld_memwb  = 1'b1;
        stall_inc = 1'b1;
      end else if (iwait) begin
        ld_ifid   = 1'b1;
        bub_ifid  = 1'b1;
        ld_idex   = 1'b1;
        ld_exmem  = 1'b1;
        ld_memwb  = 1'b1;
        stall_inc = 1'b1;
      end else begin
        ld_pc    = 1'b1;
        ld_ifid  = 1'b1;
        ld_idex  = 1'b1;
        ld_exmem = 1'b1;
        ld_memwb = 1'b1;
      end
    end
  end

  // FSM state and pending-redirect flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Controls are forced quiet while reset is held, independent of the inputs.
  assign load_pc      = reset_n & ld_pc;
  assign load_ifid    = reset_n & ld_ifid;
  assign load_idex    = reset_n & ld_idex;
  assign load_exmem   = reset_n & ld_exmem;
  assign load_memwb   = reset_n & ld_memwb;
  assign bubble_ifid  = reset_n & bub_ifid;
  assign bubble_idex  = reset_n & bub_idex;
  assign bubble_exmem = reset_n & bub_exmem;
  assign pc_redirect  = reset_n & redir;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  // A branch and a data access cannot both sit in MEM.
  a_br_vs_dmem: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(br_taken_mem && dmem_req));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes reference-model
// expectations, an independent monitor pops and compares every cycle.
module tb_pipeline_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [2:0] s1;
    logic [2:0] s2;
    logic       u1;
    logic       u2;
    logic [2:0] d;
    logic       mr;
    logic       ireq;
    logic       iresp;
    logic       dreq;
    logic       dresp;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [4:0]    ld;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0]    bub;  // {ifid, idex, exmem}
    logic          rd;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    src1_ifid, src2_ifid, dest_idex;
  logic          src1_used, src2_used, idex_memread;
  logic          imem_req, imem_resp, dmem_req, dmem_resp, br_taken_mem;
  logic          load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic          bubble_ifid, bubble_idex, bubble_exmem, pc_redirect;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src1_ifid    (src1_ifid),
    .src2_ifid    (src2_ifid),
    .src1_used    (src1_used),
    .src2_used    (src2_used),
    .dest_idex    (dest_idex),
    .idex_memread (idex_memread),
    .imem_req     (imem_req),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .br_taken_mem (br_taken_mem),
    .load_pc      (load_pc),
    .load_ifid    (load_ifid),
    .load_idex    (load_idex),
    .load_exmem   (load_exmem),
    .load_memwb   (load_memwb),
    .bubble_ifid  (bubble_ifid),
    .bubble_idex  (bubble_idex),
    .bubble_exmem (bubble_exmem),
    .pc_redirect  (pc_redirect),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // Reference model state: waiting for a fetch before a branch redirect can land.
  bit m_fetch_wait = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.ireq  = 1'b1;
    s.iresp = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    src1_ifid    = s.s1;
    src2_ifid    = s.s2;
    src1_used    = s.u1;
    src2_used    = s.u2;
    dest_idex    = s.d;
    idex_memread = s.mr;
    imem_req     = s.ireq;
    imem_resp    = s.iresp;
    dmem_req     = s.dreq;
    dmem_resp    = s.dresp;
    br_taken_mem = s.br;
  endtask

  // Rules applied per cycle; a data wait always freezes and counts a stall, and the
  // cycle it completes behaves like any normal cycle.
  task automatic model_step(input stim_t s, output exp_t e);
    bit lu, dw, iw, st_inc, fl_inc;
    lu = s.mr && ((s.u1 && s.d == s.s1) || (s.u2 && s.d == s.s2));
    dw = s.dreq && !s.dresp;
    iw = s.ireq && !s.iresp;
    st_inc = 0;
    fl_inc = 0;
    e = '0;
    e.st = m_stall[CW-1:0];
    e.fl = m_flush[CW-1:0];
    if (m_fetch_wait) begin
      if (dw) begin
        e.ld = 5'b00000;
      end else if (s.iresp) begin
        e.ld = 5'b11111; e.bub = 3'b100; e.rd = 1'b1; fl_inc = 1; m_fetch_wait = 0;
      end else begin
        e.ld = 5'b01111; e.bub = 3'b100;
      end
    end else if (dw) begin
      e.ld = 5'b00000; st_inc = 1;
    end else if (s.br && !iw) begin
      e.ld = 5'b11111; e.bub = 3'b111; e.rd = 1'b1; fl_inc = 1;
    end else if (s.br) begin
      e.ld = 5'b00111; e.bub = 3'b011; m_fetch_wait = 1;
    end else if (lu) begin
      e.ld = 5'b00111; e.bub = 3'b010; st_inc = 1;
    end else if (iw) begin
      e.ld = 5'b01111; e.bub = 3'b100; st_inc = 1;
    end else begin
      e.ld = 5'b11111;
    end
    if (st_inc && m_stall < MAXC) m_stall++;
    if (fl_inc && m_flush < MAXC) m_flush++;
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    apply(s);
    model_step(s, e);
    sb_q.push_back(e);
  endtask

  // Drop reset between edges, check the immediate effect, release on a negedge.
  task automatic async_reset(input stim_t hold, input stim_t after);
    @(posedge clk);
    #2;
    apply(hold);
    reset_n = 1'b0;
    #1;
    chk("rst_loads",   {27'd0, load_pc, load_ifid, load_idex, load_exmem, load_memwb}, 32'd0);
    chk("rst_bubbles", {29'd0, bubble_ifid, bubble_idex, bubble_exmem}, 32'd0);
    chk("rst_redir",   {31'd0, pc_redirect}, 32'd0);
    chk("rst_stall",   {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
    chk("rst_flush",   {{(32-CW){1'b0}}, flush_cnt}, 32'd0);
    m_fetch_wait = 0;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    apply(after);
    reset_n = 1'b1;
  endtask

  // Monitor: compare whatever the driver expected for this cycle.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("loads",    {27'd0, load_pc, load_ifid, load_idex, load_exmem, load_memwb}, {27'd0, e.ld});
      chk("bubbles",  {29'd0, bubble_ifid, bubble_idex, bubble_exmem}, {29'd0, e.bub});
      chk("redirect", {31'd0, pc_redirect}, {31'd0, e.rd});
      chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, {{(32-CW){1'b0}}, e.st});
      chk("flush_cnt", {{(32-CW){1'b0}}, flush_cnt}, {{(32-CW){1'b0}}, e.fl});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, idle;
    idle = idle_stim();
    reset_n = 1'b0;
    apply(idle);
    #3;
    chk("por_loads", {27'd0, load_pc, load_ifid, load_idex, load_exmem, load_memwb}, 32'd0);
    chk("por_redir", {31'd0, pc_redirect}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    cycle(idle);
    // Load-use on SR1, then a clean advance.
    s = idle; s.mr = 1; s.d = 3'd3; s.s1 = 3'd3; s.u1 = 1;
    cycle(s);
    cycle(idle);
    // Load-use through R0 on SR2.
    s = idle; s.mr = 1; s.d = 3'd0; s.s2 = 3'd0; s.u2 = 1; s.s1 = 3'd5; s.u1 = 1;
    cycle(s);
    // Matching register but source not read: no stall.
    s = idle; s.mr = 1; s.d = 3'd6; s.s1 = 3'd6; s.u1 = 0;
    cycle(s);
    // Data-memory wait for 4 cycles, then completion.
    s = idle; s.dreq = 1; s.dresp = 0;
    repeat (4) cycle(s);
    s.dresp = 1;
    cycle(s);
    cycle(idle);
    // Branch with fetch idle; branch wins over a simultaneous load-use.
    s = idle; s.br = 1;
    cycle(s);
    s.mr = 1; s.d = 3'd2; s.s1 = 3'd2; s.u1 = 1;
    cycle(s);
    // Branch while a fetch is outstanding, fetch returns three cycles later.
    s = idle; s.br = 1; s.iresp = 0;
    cycle(s);
    s.br = 0;
    repeat (2) cycle(s);
    s.iresp = 1;
    cycle(s);
    cycle(idle);
    // Data wait arriving while a redirect is pending freezes everything.
    s = idle; s.br = 1; s.iresp = 0;
    cycle(s);
    s.br = 0; s.dreq = 1;
    repeat (2) cycle(s);
    s.dreq = 0;
    cycle(s);
    s.iresp = 1;
    cycle(s);
    // Counter saturation.
    s = idle; s.dreq = 1;
    repeat (20) cycle(s);
    s.dresp = 1;
    cycle(s);
    cycle(idle);
    // Asynchronous reset in the middle of a data stall.
    s = idle; s.dreq = 1;
    repeat (3) cycle(s);
    async_reset(s, idle);
    cycle(idle);
    // Asynchronous reset while a redirect is pending.
    s = idle; s.br = 1; s.iresp = 0;
    cycle(s);
    s.br = 0;
    cycle(s);
    async_reset(s, idle);
    cycle(idle);

    // Randomized segments.
    for (int seg = 0; seg < 20; seg++) begin
      for (int c = 0; c < 40; c++) begin
        s = '0;
        s.s1    = 3'($urandom_range(0, 7));
        s.s2    = 3'($urandom_range(0, 7));
        s.d     = 3'($urandom_range(0, 7));
        s.u1    = 1'($urandom_range(0, 1));
        s.u2    = 1'($urandom_range(0, 1));
        s.mr    = 1'($urandom_range(0, 1));
        s.ireq  = ($urandom_range(0, 3) != 0);
        s.iresp = 1'($urandom_range(0, 1));
        s.br    = ($urandom_range(0, 5) == 0);
        s.dreq  = s.br ? 1'b0 : ($urandom_range(0, 3) == 0);
        s.dresp = 1'($urandom_range(0, 1));
        cycle(s);
      end
      if (seg % 4 == 3) async_reset(s, idle);
    end

    cycle(idle);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
